seq_64_add_16: RTL

//  Multi-cycle WIDTH-bit adder built on one 16-bit CLA slice. Each cycle adds one
//  16-bit slice, LSB slice first, and feeds the carry forward through a register.

---
 rtl/seq_64_add_16_pkg.sv | 12 +
 rtl/seq_64_add_16_cla.sv | 52 +++++
 rtl/seq_64_add_16.sv | 99 +++++++++
 3 files changed

// File: rtl/seq_64_add_16_pkg.sv
// Shared definitions for the slice-serial adder: FSM state encoding and slice width.
package seq_64_add_16_pkg;

  localparam int SLICE = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_64_add_16_cla.sv
// bk_16_cla_4: 16-bit adder made of four 4-bit lookahead groups whose group carries
// are resolved by a second lookahead level.
module bk_16_cla_4 (
  input  logic [15:0] x1,
  input  logic [15:0] x2,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  always_comb begin
    g = x1 & x2;
    p = x1 ^ x2;

    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end

    // Second-level lookahead: every group carry-in comes straight from cin and gg/gp.
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    c[16] = gc[4];

    s    = p ^ c[15:0];
    cout = c[16];
  end

endmodule

// File: rtl/seq_64_add_16.sv
// Multi-cycle WIDTH-bit adder: one 16-bit CLA slice per cycle, LSB slice first,
// carry chained through a register, valid/ready on both operand and result sides.
module seq_64_add_16 #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16   // must equal the CLA slice width; WIDTH a multiple of it
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  import seq_64_add_16_pkg::*;

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t             state;
  state_t             state_n;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx;
  logic [SLICE-1:0]   a_slice;
  logic [SLICE-1:0]   b_slice;
  logic [SLICE-1:0]   slice_s;
  logic               slice_cout;
  logic               last;

  assign a_slice   = a_q[idx*SLICE +: SLICE];
  assign b_slice   = b_q[idx*SLICE +: SLICE];
  assign last      = (idx == IDX_W'(NSLICE - 1));
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  bk_16_cla_4 u_cla (
    .x1   (a_slice),
    .x2   (b_slice),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (in_valid)  state_n = ST_RUN;
      ST_RUN:  if (last)      state_n = ST_DONE;
      ST_DONE: if (out_ready) state_n = ST_IDLE;
      default:                state_n = ST_IDLE;
    endcase
  end

  // NOTE: every register here uses <= so all state updates see pre-edge values;
  // the datapath registers are reset too, so a reset mid-RUN leaves no stale sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= x1;
            b_q     <= x2;
            carry_q <= cin;
            idx     <= '0;
          end
        end
        ST_RUN: begin
          s[idx*SLICE +: SLICE] <= slice_s;
          carry_q               <= slice_cout;
          idx                   <= idx + 1'b1;
          if (last) begin
            cout <= slice_cout;
            ovf  <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_s[SLICE-1] ^ slice_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
